fpu_arbiter: RTL and testbench

Sequencer and two-port arbiter in front of the 32-bit custom-float FPU (sign [31], exponent [30:21], mantissa [20:0]). It accepts operand pairs from two requesters and grants the FPU round-robin. It launches one operation at a time, waits for the FPU's completion status, and returns result and status to the owning requester. A watchdog aborts operations the FPU never completes.

---
 rtl/fpu_arbiter.sv | 156 +++++++++++++++
 tb/tb_fpu_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_arbiter.sv
// Two-requester round-robin front end for the custom-float FPU: launches one
// operation at a time, waits for completion status, and routes the result back.
module fpu_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clock_100KHz,
  input  logic        reset,

  input  logic        req0_valid,
  input  logic [31:0] req0_op_a,
  input  logic [31:0] req0_op_b,
  output logic        req0_ready,

  input  logic        req1_valid,
  input  logic [31:0] req1_op_a,
  input  logic [31:0] req1_op_b,
  output logic        req1_ready,

  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  output logic [3:0]  rsp0_status,
  output logic        rsp0_timeout,

  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  output logic [3:0]  rsp1_status,
  output logic        rsp1_timeout,

  output logic [31:0] fpu_op_a,
  output logic [31:0] fpu_op_b,
  output logic        fpu_start,
  input  logic [31:0] fpu_data,
  input  logic [3:0]  fpu_status,

  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT_CYCLES);

  state_e      state_q;
  logic        owner_q;
  logic        last_q;
  logic [7:0]  wdog_q, wdog_d;
  logic        expire;

  logic [31:0] fpu_op_a_q, fpu_op_b_q;
  logic        fpu_start_q;
  logic        busy_q;

  logic        rsp0_valid_q, rsp1_valid_q;
  logic [31:0] rsp0_data_q, rsp1_data_q;
  logic [3:0]  rsp0_status_q, rsp1_status_q;
  logic        rsp0_timeout_q, rsp1_timeout_q;

  logic        grant;
  logic        accept;
  logic        handshake;

  always_comb begin
    grant = 1'b0;
    // On contention, the requester not granted last wins.
    if (req0_valid && req1_valid) begin
      grant = ~last_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
    accept     = (state_q == StIdle) && reset;
    req0_ready = accept && req0_valid && !grant;
    req1_ready = accept && req1_valid && grant;
    handshake  = req0_ready || req1_ready;
    wdog_d     = wdog_q + 8'd1;
    expire     = (wdog_d == TimeoutCnt);
  end

  always_ff @(posedge clock_100KHz) begin
    if (!reset) begin
      state_q        <= StIdle;
      owner_q        <= 1'b0;
      last_q         <= 1'b1;
      wdog_q         <= 8'd0;
      fpu_op_a_q     <= 32'd0;
      fpu_op_b_q     <= 32'd0;
      fpu_start_q    <= 1'b0;
      busy_q         <= 1'b0;
      rsp0_valid_q   <= 1'b0;
      rsp0_data_q    <= 32'd0;
      rsp0_status_q  <= 4'd0;
      rsp0_timeout_q <= 1'b0;
      rsp1_valid_q   <= 1'b0;
      rsp1_data_q    <= 32'd0;
      rsp1_status_q  <= 4'd0;
      rsp1_timeout_q <= 1'b0;
    end else begin
      fpu_start_q  <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (handshake) begin
            fpu_op_a_q  <= grant ? req1_op_a : req0_op_a;
            fpu_op_b_q  <= grant ? req1_op_b : req0_op_b;
            owner_q     <= grant;
            fpu_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          // Status seen here may belong to the previous operation.
          wdog_q  <= 8'd0;
          state_q <= StWait;
        end
        StWait: begin
          if (fpu_status != 4'd0 || expire) begin
            if (owner_q) begin
              rsp1_valid_q   <= 1'b1;
              rsp1_data_q    <= (fpu_status != 4'd0) ? fpu_data : 32'd0;
              rsp1_status_q  <= fpu_status;
              rsp1_timeout_q <= (fpu_status == 4'd0);
            end else begin
              rsp0_valid_q   <= 1'b1;
              rsp0_data_q    <= (fpu_status != 4'd0) ? fpu_data : 32'd0;
              rsp0_status_q  <= fpu_status;
              rsp0_timeout_q <= (fpu_status == 4'd0);
            end
            state_q <= StResp;
          end else begin
            wdog_q <= wdog_d;
          end
        end
        StResp: begin
          last_q  <= owner_q;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign fpu_op_a     = fpu_op_a_q;
  assign fpu_op_b     = fpu_op_b_q;
  assign fpu_start    = fpu_start_q;
  assign busy         = busy_q;
  assign rsp0_valid   = rsp0_valid_q;
  assign rsp0_data    = rsp0_data_q;
  assign rsp0_status  = rsp0_status_q;
  assign rsp0_timeout = rsp0_timeout_q;
  assign rsp1_valid   = rsp1_valid_q;
  assign rsp1_data    = rsp1_data_q;
  assign rsp1_status  = rsp1_status_q;
  assign rsp1_timeout = rsp1_timeout_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboard bench for fpu_arbiter: directed requests with a programmable FPU
// model; a monitor pops expected responses and checks data, status and cycle.
module tb_fpu_arbiter;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_op_a = '0, req0_op_b = '0, req1_op_a = '0, req1_op_b = '0;
  logic [31:0] fpu_data = '0;
  logic [3:0]  fpu_status = '0;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid, rsp0_timeout, rsp1_timeout;
  logic [31:0] rsp0_data, rsp1_data, fpu_op_a, fpu_op_b;
  logic [3:0]  rsp0_status, rsp1_status;
  logic        fpu_start, busy;

  fpu_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clock_100KHz(clk), .reset(rst_n),
    .req0_valid(req0_valid), .req0_op_a(req0_op_a), .req0_op_b(req0_op_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op_a(req1_op_a), .req1_op_b(req1_op_b),
    .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_status(rsp0_status),
    .rsp0_timeout(rsp0_timeout),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_status(rsp1_status),
    .rsp1_timeout(rsp1_timeout),
    .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b), .fpu_start(fpu_start),
    .fpu_data(fpu_data), .fpu_status(fpu_status), .busy(busy)
  );

  typedef struct {
    int          port;
    logic [31:0] data;
    logic [3:0]  st;
    logic        to;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Per-operation behaviour of the FPU model, set by the driver at handshake.
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  logic [3:0]  m_st = '0, m_stale = '0;
  int          m_lat = 1;

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // FPU model: drives stale status during ISSUE, zero while busy, then holds result.
  initial begin : fpu_model
    int          k;
    int          lat;
    bit          active;
    logic [31:0] res;
    logic [3:0]  st;
    active = 1'b0;
    k = 0;
    lat = 1;
    res = '0;
    st = '0;
    forever begin
      @(negedge clk);
      if (fpu_start) begin
        chk("fpu_op_a", fpu_op_a, m_a);
        chk("fpu_op_b", fpu_op_b, m_b);
        k = 0;
        lat = m_lat;
        res = m_res;
        st = m_st;
        active = 1'b1;
        fpu_status = m_stale;
      end else if (active) begin
        k++;
        if (k >= lat) begin
          fpu_status = st;
          fpu_data = res;
          active = 1'b0;
        end else begin
          fpu_status = 4'd0;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp0_valid=%0b rsp1_valid=%0b, expected none",
                   rsp0_valid, rsp1_valid);
        end else begin
          e = sb.pop_front();
          chk("rsp_onehot", 32'(rsp0_valid & rsp1_valid), 0);
          chk("rsp_port", 32'(rsp1_valid), e.port);
          chk("rsp_data", rsp1_valid ? rsp1_data : rsp0_data, e.data);
          chk("rsp_status", 32'(rsp1_valid ? rsp1_status : rsp0_status), 32'(e.st));
          chk("rsp_timeout", 32'(rsp1_valid ? rsp1_timeout : rsp0_timeout), 32'(e.to));
          chk("rsp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic drive_req(input int port, input logic v, input logic [31:0] a,
                           input logic [31:0] b);
    if (port == 1) begin
      req1_valid = v; req1_op_a = a; req1_op_b = b;
    end else begin
      req0_valid = v; req0_op_a = a; req0_op_b = b;
    end
  endtask

  task automatic push_exp(input int port, input int c, input logic [31:0] res,
                          input logic [3:0] st, input int lat);
    exp_t e;
    e.port = port;
    if (lat <= T) begin
      e.data = res; e.st = st; e.to = 1'b0; e.cyc = c + 2 + lat;
    end else begin
      e.data = 32'd0; e.st = 4'd0; e.to = 1'b1; e.cyc = c + 2 + T;
    end
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200; n++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_wait: got %0d pending responses, expected 0", sb.size());
      sb.delete();
    end
    chk("busy_idle", 32'(busy), 0);
  endtask

  task automatic check_reset_vals();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fpu_start", 32'(fpu_start), 0);
    chk("rst_ready0", 32'(req0_ready), 0);
    chk("rst_ready1", 32'(req1_ready), 0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 0);
    chk("rst_rsp0_timeout", 32'(rsp0_timeout), 0);
    chk("rst_rsp1_timeout", 32'(rsp1_timeout), 0);
    chk("rst_fpu_op_a", fpu_op_a, 0);
    chk("rst_fpu_op_b", fpu_op_b, 0);
    chk("rst_rsp0_data", rsp0_data, 0);
    chk("rst_rsp1_data", rsp1_data, 0);
    chk("rst_rsp0_status", 32'(rsp0_status), 0);
    chk("rst_rsp1_status", 32'(rsp1_status), 0);
  endtask

  task automatic issue(input int port, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [3:0] st,
                       input logic [3:0] stale, input int lat, input bit expect_rsp);
    int   c;
    bit   got;
    logic r_own, r_oth;
    got = 1'b0;
    r_own = 1'b0;
    r_oth = 1'b0;
    @(negedge clk);
    drive_req(port, 1'b1, a, b);
    for (int w = 0; w < 20; w++) begin
      #1;
      r_own = (port == 1) ? req1_ready : req0_ready;
      r_oth = (port == 1) ? req0_ready : req1_ready;
      if (r_own) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("req_ready", 32'(got), 1);
    chk("other_ready", 32'(r_oth), 0);
    if (!got) begin
      drive_req(port, 1'b0, 32'd0, 32'd0);
      return;
    end
    c = cyc;
    m_a = a; m_b = b; m_res = res; m_st = st; m_stale = stale; m_lat = lat;
    if (expect_rsp) push_exp(port, c, res, st, lat);
    @(negedge clk);
    drive_req(port, 1'b0, 32'd0, 32'd0);
    chk("fpu_start_issue", 32'(fpu_start), 1);
    chk("busy_issue", 32'(busy), 1);
    @(negedge clk);
    chk("fpu_start_pulse", 32'(fpu_start), 0);
    chk("busy_wait", 32'(busy), 1);
    if (expect_rsp) wait_drain();
  endtask

  task automatic contention();
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic [31:0] tr [4];
    logic [3:0]  ts [4];
    int          exp_g;
    int          c;
    int          prev_c;
    bit          got;
    ta = '{32'h40000000, 32'h40800000, 32'h3FE00000, 32'h41000000};
    tb = '{32'h40400000, 32'h40800000, 32'h3FE00000, 32'h40000000};
    tr = '{32'h40500000, 32'h40A00000, 32'h40000000, 32'h41100000};
    ts = '{4'b0001, 4'b0001, 4'b1111, 4'b0011};
    exp_g = 0;
    prev_c = 0;
    @(negedge clk);
    drive_req(0, 1'b1, ta[0], tb[0]);
    drive_req(1, 1'b1, ta[1], tb[1]);
    for (int n = 0; n < 4; n++) begin
      got = 1'b0;
      for (int w = 0; w < 20; w++) begin
        #1;
        if (req0_ready || req1_ready) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("cont_handshake", 32'(got), 1);
      if (!got) break;
      chk("cont_grant0", 32'(req0_ready), 32'(exp_g == 0));
      chk("cont_grant1", 32'(req1_ready), 32'(exp_g == 1));
      c = cyc;
      if (n > 0) chk("cont_spacing", c - prev_c, 4);
      prev_c = c;
      m_a = ta[n]; m_b = tb[n]; m_res = tr[n]; m_st = ts[n]; m_stale = 4'b0001; m_lat = 1;
      push_exp(exp_g, c, tr[n], ts[n], 1);
      @(negedge clk);
      if (n + 2 < 4) drive_req(exp_g, 1'b1, ta[n + 2], tb[n + 2]);
      exp_g = 1 - exp_g;
    end
    drive_req(0, 1'b0, 32'd0, 32'd0);
    drive_req(1, 1'b0, 32'd0, 32'd0);
    wait_drain();
  endtask

  initial begin : stimulus
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;

    contention();
    // 2.0 + 2.0 = 4.0 in the bias-511 custom format.
    issue(0, 32'h40000000, 32'h40000000, 32'h40200000, 4'b0001, 4'b0001, 1, 1'b1);
    issue(0, 32'h7FC00000, 32'h7FC00000, 32'h7FE00000, 4'b0011, 4'b1111, 4, 1'b1);
    issue(1, 32'h40000000, 32'h3FE00000, 32'h12345678, 4'b0001, 4'b0011, 255, 1'b1);
    issue(1, 32'h40800000, 32'h40000000, 32'h40A00000, 4'b0001, 4'b0000, 2, 1'b1);
    issue(0, 32'h00200000, 32'h00200000, 32'h00100000, 4'b0111, 4'b0001, T, 1'b1);

    // Abandon an operation in WAIT with a one-cycle reset pulse.
    issue(1, 32'h3FE00000, 32'h3FE00000, 32'hCAFEF00D, 4'b0001, 4'b0001, 255, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    issue(0, 32'h40200000, 32'h40000000, 32'h40300000, 4'b1111, 4'b0001, 3, 1'b1);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : global_timeout
    #100000;
    $display("FAIL global_timeout: simulation did not complete in time");
    $fatal(1, "global timeout");
  end

endmodule
